// File: rtl/xc_malu_arb.sv
// Round-robin arbiter and sequencer sharing one xc_malu between two requesters.
// One operation in flight at a time: accept, run, respond, then flush the MALU.
module xc_malu_arb #(
  parameter int TMO_W = 7
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        flush,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [27:0] req_uop,
  input  logic [9:0]  req_pw,
  input  logic [63:0] req_rs1,
  input  logic [63:0] req_rs2,
  input  logic [63:0] req_rs3,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [63:0] rsp_result,
  output logic        rsp_tmo,
  output logic        malu_valid,
  output logic        malu_flush,
  output logic [13:0] malu_uop,
  output logic [4:0]  malu_pw,
  output logic [31:0] malu_rs1,
  output logic [31:0] malu_rs2,
  output logic [31:0] malu_rs3,
  input  logic [63:0] malu_result,
  input  logic        malu_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, CLEAR} state_t;

  // Timeout fires on the BUSY cycle that would take the counter to all-ones.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((1 << TMO_W) - 2);

  state_t            state_q, state_d;
  logic              owner_q;
  logic              last_grant_q;
  logic [TMO_W-1:0]  tmo_cnt_q;
  logic              tmo_q;
  logic [63:0]       result_q;
  logic [13:0]       uop_q;
  logic [4:0]        pw_q;
  logic [31:0]       rs1_q, rs2_q, rs3_q;

  logic              grant_valid;
  logic              grant;
  logic              accept;
  logic              take_result;
  logic              timeout;

  always_comb begin
    grant_valid = |req_valid;
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant_q;
      default: grant = 1'b0;
    endcase
  end

  // flush overrides every other transition, including a pending handshake.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    take_result = 1'b0;
    timeout     = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            accept  = 1'b1;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (malu_ready) begin
            take_result = 1'b1;
            state_d     = RESP;
          end else if (tmo_cnt_q == TMO_LAST) begin
            timeout = 1'b1;
            state_d = RESP;
          end
        end
        RESP: begin
          if (rsp_ready[owner_q]) begin
            state_d = CLEAR;
          end
        end
        CLEAR: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Combinational outputs are gated by resetn so nothing leaks while in reset.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    if (accept && resetn) begin
      req_ready[grant] = 1'b1;
    end
    if ((state_q == RESP) && !flush) begin
      rsp_valid[owner_q] = 1'b1;
    end
    malu_valid = (state_q == BUSY) && !flush;
    malu_flush = resetn && (flush || (state_q == CLEAR));
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      tmo_cnt_q    <= '0;
      tmo_q        <= 1'b0;
      result_q     <= '0;
    end else begin
      if (accept) begin
        owner_q      <= grant;
        last_grant_q <= grant;
        tmo_cnt_q    <= '0;
      end else if ((state_q == BUSY) && !flush && !malu_ready) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
      if (take_result) begin
        result_q <= malu_result;
        tmo_q    <= 1'b0;
      end else if (timeout) begin
        result_q <= '0;
        tmo_q    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      uop_q <= '0;
      pw_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rs3_q <= '0;
    end else if (accept) begin
      uop_q <= grant ? req_uop[27:14]  : req_uop[13:0];
      pw_q  <= grant ? req_pw[9:5]     : req_pw[4:0];
      rs1_q <= grant ? req_rs1[63:32]  : req_rs1[31:0];
      rs2_q <= grant ? req_rs2[63:32]  : req_rs2[31:0];
      rs3_q <= grant ? req_rs3[63:32]  : req_rs3[31:0];
    end else if (state_q == CLEAR) begin
      uop_q <= '0;
    end
  end

  assign rsp_result = result_q;
  assign rsp_tmo    = tmo_q;
  assign malu_uop   = uop_q;
  assign malu_pw    = pw_q;
  assign malu_rs1   = rs1_q;
  assign malu_rs2   = rs2_q;
  assign malu_rs3   = rs3_q;

endmodule
